comb_bist_ctrl: RTL and testbench
=================================

# comb_bist_ctrl

Synthesizable built-in self-test controller for `combinationalcircuit`. It drives the DUT input side and reads back its output side across all three `userinput` modes: encoder/demux, decoder/mux, and decoder/full-adder. It compares every response against an internal golden model and reports a pass/fail summary. It sits beside `combinationalcircuit` on the board-level top and replaces the simulation-only stimulus sweep with a clocked, repeatable on-chip sweep.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: idle cycles between applying a vector and sampling the response. Legal range is 0..15.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled; launches a sweep when the block is idle.
- `userinput` out 2: DUT mode select.
- `d0`,`d1`,`d2`,`d3`,`I` out 1 each: encoder, demux and mux data inputs.
- `a0`,`a1` out 1 each: 2-bit decoder and mux select.
- `a`,`b`,`c` out 1 each: 3-bit decoder and full-adder inputs.
- `y0`..`y11`,`s0`,`s1`,`x`,`sum`,`carry` in 1 each: DUT responses.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep finished. Held high until the next accepted `start`.
- `pass` out 1: equals `done` and `err_count` == 0.
- `err_count` out 8: number of mismatching vectors. Saturates at 255.
- `fail_valid` out 1: at least one mismatch has been captured.
- `fail_mode` out 2: mode of the first mismatching vector.
- `fail_idx` out 3: index of the first mismatching vector.

## Operation
- FSM states are IDLE, APPLY, SETTLE, CHECK and FIN.
  - IDLE → APPLY when `start`=1. Entering APPLY clears `err_count`, `fail_*` and `done`, sets `busy`, and sets mode=0, idx=0.
  - APPLY lasts 1 cycle and registers the DUT drive outputs for the current (mode, idx).
  - APPLY → SETTLE. SETTLE lasts `SETTLE_CYCLES` cycles. If `SETTLE_CYCLES`=0, APPLY → CHECK directly.
  - CHECK lasts 1 cycle. It compares the masked DUT outputs against the golden value.
    - On mismatch, `err_count` is incremented (saturating). On the first mismatch only, `fail_mode`/`fail_idx` are captured and `fail_valid` is set.
  - CHECK → APPLY with the next vector. After mode 2, idx 7, CHECK → FIN.
  - FIN lasts 1 cycle: sets `done`, clears `busy`, then → IDLE.
- Vector sequence: 16 vectors total.
  - Mode 0, idx k = 0..3:
    - Drive: d = one-hot k (d0 for k=0), `I`=1.
    - Expected: {s1,s0}=k; y0..y3 one-hot at y_k.
  - Mode 1, idx k = 0..3:
    - Drive: {a1,a0}=k; d0..d3 held at 1,0,1,0.
    - Expected: y8..y11 one-hot at y(8+k); `x` = d_k, i.e. `x` = ~k[0].
  - Mode 2, idx k = 0..7:
    - Drive: {a,b,c}=k.
    - Expected: y0..y7 one-hot at y_k; `sum` = a^b^c; `carry` = majority(a,b,c).
- Compare mask: only the outputs listed for the current mode are compared. All other DUT outputs are don't-care.
- Drive outputs not used by the current mode are held at 0.
- `start` is ignored while `busy`. `start` held high in IDLE after FIN immediately relaunches a sweep.

## Timing
- Reset values:
  - State = IDLE.
  - All drive outputs = 0.
  - `busy`, `done`, `pass`, `fail_valid` = 0.
  - `err_count`, `fail_mode`, `fail_idx` = 0.
- Latency:
  - The `start` sample cycle is IDLE; APPLY is the next cycle.
  - Each vector takes 2+`SETTLE_CYCLES` cycles.
  - `done` rises 16·(2+`SETTLE_CYCLES`)+1 cycles after the APPLY of vector 0. With the default, that is 65 cycles.
- Drive outputs change only on the clock edge that enters APPLY. They are stable through SETTLE and CHECK.
- The DUT response is sampled combinationally in the CHECK cycle. The result is registered on the CHECK→next edge.
- Reset asserted mid-sweep aborts immediately and asynchronously to the reset values. No partial result is retained.

## Structure
- Package `comb_bist_pkg` holds:
  - the state enum;
  - mode constants MODE_ENC_DEMUX=0, MODE_DEC_MUX=1, MODE_DEC_FA=2;
  - per-mode vector counts (4, 4, 8);
  - `ERR_MAX`=255.
- Sub-module `comb_bist_golden` is purely combinational.
  - Inputs: (mode, idx).
  - Outputs: the drive vector, the expected response and the compare mask.
  - The same instance is used for both drive and check.

## Test plan
- Correct behavioural DUT model, `SETTLE_CYCLES`=2, `start` pulse → `done`=1 after exactly 65 cycles from the first APPLY; `pass`=1, `err_count`=0, `fail_valid`=0.
- DUT `carry` stuck-at-0 → failures at mode 2, idx 3, 5, 6, 7; `err_count`=4, `fail_mode`=2, `fail_idx`=3, `pass`=0.
- DUT `s1`/`s0` swapped → mode 0 idx 1 and 2 fail; `err_count`=2, `fail_mode`=0, `fail_idx`=1.
- `SETTLE_CYCLES`=0 with the correct model → `done` after 33 cycles and `pass`=1. Drive outputs change every 2 cycles.
- `rst_n` low during mode 1 idx 2 → all outputs return to reset values immediately. A subsequent `start` runs a full sweep from mode 0 idx 0 with `err_count` restarting at 0.
- `start` toggled during `busy` → no restart and the sweep timing is unchanged. `start` held high → a second sweep begins the cycle after FIN, with `done` cleared on its APPLY.

Source files
------------

// File: rtl/comb_bist_pkg.sv
// Shared types and constants for the combinational-circuit BIST controller.
package comb_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_FIN
    } state_t;

    localparam logic [1:0] MODE_ENC_DEMUX = 2'd0;
    localparam logic [1:0] MODE_DEC_MUX   = 2'd1;
    localparam logic [1:0] MODE_DEC_FA    = 2'd2;

    localparam int VEC_ENC_DEMUX = 4;
    localparam int VEC_DEC_MUX   = 4;
    localparam int VEC_DEC_FA    = 8;

    localparam logic [7:0] ERR_MAX = 8'd255;

    typedef struct packed {
        logic [1:0] userinput;
        logic [3:0] d;      // d[0] is d0
        logic       i;
        logic [1:0] sel;    // {a1, a0}
        logic [2:0] abc;    // {a, b, c}
    } drive_t;

    typedef struct packed {
        logic        carry;
        logic        sum;
        logic        x;
        logic        s1;
        logic        s0;
        logic [11:0] y;     // y[0] is y0
    } resp_t;

    function automatic logic [2:0] last_idx(input logic [1:0] mode);
        case (mode)
            MODE_ENC_DEMUX: return 3'(VEC_ENC_DEMUX - 1);
            MODE_DEC_MUX:   return 3'(VEC_DEC_MUX - 1);
            default:        return 3'(VEC_DEC_FA - 1);
        endcase
    endfunction

endpackage

// File: rtl/comb_bist_golden.sv
// Golden model: maps (mode, idx) to the drive vector, expected response and compare mask.
module comb_bist_golden
    import comb_bist_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] idx,
    output drive_t     drive,
    output resp_t      exp_resp,
    output resp_t      mask
);

    always_comb begin
        drive    = '0;
        exp_resp = '0;
        mask     = '0;
        case (mode)
            MODE_ENC_DEMUX: begin
                drive.userinput          = MODE_ENC_DEMUX;
                drive.d                  = 4'b0001 << idx[1:0];
                drive.i                  = 1'b1;
                exp_resp.s1              = idx[1];
                exp_resp.s0              = idx[0];
                exp_resp.y[idx[1:0]]     = 1'b1;
                mask.s1                  = 1'b1;
                mask.s0                  = 1'b1;
                mask.y[3:0]              = 4'hf;
            end
            MODE_DEC_MUX: begin
                drive.userinput          = MODE_DEC_MUX;
                drive.d                  = 4'b0101;
                drive.sel                = idx[1:0];
                exp_resp.y[{2'b10, idx[1:0]}] = 1'b1;
                exp_resp.x               = ~idx[0];
                mask.y[11:8]             = 4'hf;
                mask.x                   = 1'b1;
            end
            MODE_DEC_FA: begin
                drive.userinput          = MODE_DEC_FA;
                drive.abc                = idx;
                exp_resp.y[idx]          = 1'b1;
                exp_resp.sum             = ^idx;
                exp_resp.carry           = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
                mask.y[7:0]              = 8'hff;
                mask.sum                 = 1'b1;
                mask.carry               = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/comb_bist_ctrl.sv
// BIST sequencer for combinationalcircuit: sweeps 16 vectors over three modes and
// reports error count plus the first failing (mode, idx).
module comb_bist_ctrl
    import comb_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] userinput,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       I,
    output logic       a0,
    output logic       a1,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y0,
    input  logic       y1,
    input  logic       y2,
    input  logic       y3,
    input  logic       y4,
    input  logic       y5,
    input  logic       y6,
    input  logic       y7,
    input  logic       y8,
    input  logic       y9,
    input  logic       y10,
    input  logic       y11,
    input  logic       s0,
    input  logic       s1,
    input  logic       x,
    input  logic       sum,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_mode,
    output logic [2:0] fail_idx
);

    state_t     state;
    logic [1:0] mode;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    drive_t     drive_q;
    resp_t      exp_q;
    resp_t      mask_q;

    logic [1:0] g_mode;
    logic [2:0] g_idx;
    drive_t     g_drive;
    resp_t      g_exp;
    resp_t      g_mask;
    resp_t      dut_resp;
    logic       last_vec;
    logic       mismatch;

    // The golden block sees the upcoming vector in IDLE/CHECK (to load the drive
    // registers on the APPLY edge) and the current one in APPLY (to latch expect/mask).
    always_comb begin
        last_vec = (idx == last_idx(mode));
        g_mode   = mode;
        g_idx    = idx;
        if (state == ST_IDLE) begin
            g_mode = MODE_ENC_DEMUX;
            g_idx  = '0;
        end else if (state == ST_CHECK) begin
            if (last_vec) begin
                g_mode = mode + 2'd1;
                g_idx  = '0;
            end else begin
                g_idx  = idx + 3'd1;
            end
        end
    end

    comb_bist_golden u_golden (
        .mode     (g_mode),
        .idx      (g_idx),
        .drive    (g_drive),
        .exp_resp (g_exp),
        .mask     (g_mask)
    );

    assign dut_resp = '{carry: carry, sum: sum, x: x, s1: s1, s0: s0,
                        y: {y11, y10, y9, y8, y7, y6, y5, y4, y3, y2, y1, y0}};
    assign mismatch = |((dut_resp ^ exp_q) & mask_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode       <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            drive_q    <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_mode  <= '0;
            fail_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        mode       <= g_mode;
                        idx        <= g_idx;
                        drive_q    <= g_drive;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_mode  <= '0;
                        fail_idx   <= '0;
                    end
                end
                ST_APPLY: begin
                    exp_q  <= g_exp;
                    mask_q <= g_mask;
                    if (SETTLE_CYCLES == 0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_CHECK;
                    else                  settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 8'd1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_mode  <= mode;
                            fail_idx   <= idx;
                        end
                    end
                    if (mode == MODE_DEC_FA && last_vec) begin
                        state <= ST_FIN;
                    end else begin
                        state   <= ST_APPLY;
                        mode    <= g_mode;
                        idx     <= g_idx;
                        drive_q <= g_drive;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign userinput = drive_q.userinput;
    assign d0        = drive_q.d[0];
    assign d1        = drive_q.d[1];
    assign d2        = drive_q.d[2];
    assign d3        = drive_q.d[3];
    assign I         = drive_q.i;
    assign a1        = drive_q.sel[1];
    assign a0        = drive_q.sel[0];
    assign a         = drive_q.abc[2];
    assign b         = drive_q.abc[1];
    assign c         = drive_q.abc[0];
    assign pass      = done && (err_count == '0);

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Bench for comb_bist_ctrl: behavioural DUT with injectable faults, table of sweeps,
// and hand-written sequences for reset, start handling and zero settle time.
module tb_comb_bist_ctrl;

    localparam int F_NONE   = 0;
    localparam int F_CARRY0 = 1;
    localparam int F_SWAP   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;
    logic [16:0] noise = '0;
    always @(negedge clk) noise = 17'($urandom);

    int          fault_a;
    logic [15:0] corrupt_a;

    // Instance A: default settle time, faulty DUT model
    logic [1:0] ui_a;
    logic       d0_a, d1_a, d2_a, d3_a, i_a, a0_a, a1_a, pa_a, pb_a, pc_a;
    logic [16:0] r_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [7:0] err_a;
    logic [1:0] fm_a;
    logic [2:0] fi_a;

    // Instance B: zero settle time, clean DUT model
    logic [1:0] ui_b;
    logic       d0_b, d1_b, d2_b, d3_b, i_b, a0_b, a1_b, pa_b, pb_b, pc_b;
    logic [16:0] r_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [7:0] err_b;
    logic [1:0] fm_b;
    logic [2:0] fi_b;

    int n_chk = 0;
    int n_fail = 0;

    // Response bit layout: [11:0]=y, 12=s0, 13=s1, 14=x, 15=sum, 16=carry.
    // Bits a mode does not define carry random noise.
    function automatic logic [16:0] dut_model(input logic [1:0] ui, input logic [3:0] d,
                                              input logic i_in, input logic [1:0] sel,
                                              input logic [2:0] abc, input int fault,
                                              input logic [15:0] corrupt, input logic [16:0] nz);
        logic [16:0] r;
        int enc, s, v;
        r = nz;
        case (ui)
            2'd0: begin
                enc = d[3] ? 3 : d[2] ? 2 : d[1] ? 1 : 0;
                for (int k = 0; k < 4; k++) r[k] = (enc == k) && i_in;
                r[12] = (enc % 2) == 1;
                r[13] = (enc / 2) == 1;
                if (fault == F_SWAP) begin
                    r[12] = (enc / 2) == 1;
                    r[13] = (enc % 2) == 1;
                end
                if (corrupt[enc]) r[12] = ~r[12];
            end
            2'd1: begin
                s = int'(sel);
                for (int k = 0; k < 4; k++) r[8+k] = (s == k);
                r[14] = d[s];
                if (corrupt[4+s]) r[14] = ~r[14];
            end
            2'd2: begin
                v = int'(abc);
                for (int k = 0; k < 8; k++) r[k] = (v == k);
                r[15] = ($countones(abc) % 2) == 1;
                r[16] = $countones(abc) >= 2;
                if (fault == F_CARRY0) r[16] = 1'b0;
                if (corrupt[8+v]) r[15] = ~r[15];
            end
            default: ;
        endcase
        return r;
    endfunction

    assign r_a = dut_model(ui_a, {d3_a, d2_a, d1_a, d0_a}, i_a, {a1_a, a0_a}, {pa_a, pb_a, pc_a},
                           fault_a, corrupt_a, noise);
    assign r_b = dut_model(ui_b, {d3_b, d2_b, d1_b, d0_b}, i_b, {a1_b, a0_b}, {pa_b, pb_b, pc_b},
                           F_NONE, 16'h0, noise);

    comb_bist_ctrl #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .userinput(ui_a),
        .d0(d0_a), .d1(d1_a), .d2(d2_a), .d3(d3_a), .I(i_a), .a0(a0_a), .a1(a1_a),
        .a(pa_a), .b(pb_a), .c(pc_a),
        .y0(r_a[0]), .y1(r_a[1]), .y2(r_a[2]), .y3(r_a[3]), .y4(r_a[4]), .y5(r_a[5]),
        .y6(r_a[6]), .y7(r_a[7]), .y8(r_a[8]), .y9(r_a[9]), .y10(r_a[10]), .y11(r_a[11]),
        .s0(r_a[12]), .s1(r_a[13]), .x(r_a[14]), .sum(r_a[15]), .carry(r_a[16]),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_mode(fm_a), .fail_idx(fi_a)
    );

    comb_bist_ctrl #(.SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .userinput(ui_b),
        .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .I(i_b), .a0(a0_b), .a1(a1_b),
        .a(pa_b), .b(pb_b), .c(pc_b),
        .y0(r_b[0]), .y1(r_b[1]), .y2(r_b[2]), .y3(r_b[3]), .y4(r_b[4]), .y5(r_b[5]),
        .y6(r_b[6]), .y7(r_b[7]), .y8(r_b[8]), .y9(r_b[9]), .y10(r_b[10]), .y11(r_b[11]),
        .s0(r_b[12]), .s1(r_b[13]), .x(r_b[14]), .sum(r_b[15]), .carry(r_b[16]),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_mode(fm_b), .fail_idx(fi_b)
    );

    // {userinput, d3..d0, I, a1, a0, a, b, c}
    function automatic logic [11:0] drv_a();
        return {ui_a, d3_a, d2_a, d1_a, d0_a, i_a, a1_a, a0_a, pa_a, pb_a, pc_a};
    endfunction
    function automatic logic [11:0] drv_b();
        return {ui_b, d3_b, d2_b, d1_b, d0_b, i_b, a1_b, a0_b, pa_b, pb_b, pc_b};
    endfunction

    // Vector v = 0..15 in sweep order.
    function automatic logic [11:0] spec_drive(input int v);
        if (v < 4)      return {2'd0, 4'(1 << v), 1'b1, 2'b00, 3'b000};
        else if (v < 8) return {2'd1, 4'b0101, 1'b0, 2'(v - 4), 3'b000};
        else            return {2'd2, 4'b0000, 1'b0, 2'b00, 3'(v - 8)};
    endfunction

    function automatic void ref_result(input int fault, input logic [15:0] corrupt,
                                       output int errs, output int first);
        int ones;
        bit bad;
        errs  = 0;
        first = -1;
        for (int v = 0; v < 16; v++) begin
            bad = corrupt[v];
            if (fault == F_CARRY0 && v >= 8) begin
                ones = ((v - 8) & 1) + (((v - 8) >> 1) & 1) + (((v - 8) >> 2) & 1);
                if (ones >= 2) bad = 1'b1;
            end
            if (fault == F_SWAP && (v == 1 || v == 2)) bad = 1'b1;
            if (bad) begin
                errs++;
                if (first < 0) first = v;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done_a(input bit toggle, output int lat);
        lat = 0;
        while (!done_a && lat < 300) begin
            if (toggle) start_a = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        if (toggle) start_a = 1'b0;
    endtask

    task automatic launch_a(input bit toggle, output int lat);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("apply_busy", int'(busy_a), 1);
        chk("apply_done_clr", int'(done_a), 0);
        chk("apply_drive_v0", int'(drv_a()), int'(spec_drive(0)));
        wait_done_a(toggle, lat);
    endtask

    typedef struct {
        int          fault;
        logic [15:0] corrupt;
        int          exp_err;
        int          exp_pass;
        int          exp_fv;
        int          exp_fm;
        int          exp_fi;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        int lat, errs, first;

        tbl[0] = '{F_NONE,   16'h0000, 0, 1, 0, 0, 0};
        tbl[1] = '{F_CARRY0, 16'h0000, 4, 0, 1, 2, 3};
        tbl[2] = '{F_SWAP,   16'h0000, 2, 0, 1, 0, 1};
        for (int t = 3; t < 9; t++) begin
            tbl[t].fault   = int'($urandom_range(0, 2));
            tbl[t].corrupt = (t < 6) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
            ref_result(tbl[t].fault, tbl[t].corrupt, errs, first);
            tbl[t].exp_err  = errs;
            tbl[t].exp_pass = (errs == 0);
            tbl[t].exp_fv   = (errs != 0);
            tbl[t].exp_fm   = (first < 0) ? 0 : (first < 4) ? 0 : (first < 8) ? 1 : 2;
            tbl[t].exp_fi   = (first < 0) ? 0 : (first < 4) ? first : (first < 8) ? first - 4 : first - 8;
        end

        fault_a   = F_NONE;
        corrupt_a = '0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        rst_n     = 1'b1;
        #3 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_fail_valid", int'(fv_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_fail_mode", int'(fm_a), 0);
        chk("rst_fail_idx", int'(fi_a), 0);
        chk("rst_drive", int'(drv_a()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++) begin
            fault_a   = tbl[t].fault;
            corrupt_a = tbl[t].corrupt;
            launch_a(1'b0, lat);
            chk($sformatf("t%0d_latency", t), lat, 65);
            chk($sformatf("t%0d_err", t), int'(err_a), tbl[t].exp_err);
            chk($sformatf("t%0d_pass", t), int'(pass_a), tbl[t].exp_pass);
            chk($sformatf("t%0d_busy", t), int'(busy_a), 0);
            chk($sformatf("t%0d_fail_valid", t), int'(fv_a), tbl[t].exp_fv);
            if (tbl[t].exp_fv != 0) begin
                chk($sformatf("t%0d_fail_mode", t), int'(fm_a), tbl[t].exp_fm);
                chk($sformatf("t%0d_fail_idx", t), int'(fi_a), tbl[t].exp_fi);
            end
        end

        // zero settle time: vector changes every 2 cycles, done after 33
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 300) begin
            if (lat < 32) chk($sformatf("s0_drive_c%0d", lat), int'(drv_b()), int'(spec_drive(lat / 2)));
            @(posedge clk); #1;
            lat++;
        end
        chk("s0_latency", lat, 33);
        chk("s0_pass", int'(pass_b), 1);
        chk("s0_err", int'(err_b), 0);
        chk("s0_fail_valid", int'(fv_b), 0);
        chk("s0_fail_mode", int'(fm_b), 0);
        chk("s0_fail_idx", int'(fi_b), 0);

        // start toggled while busy must not disturb the sweep
        fault_a   = F_NONE;
        corrupt_a = 16'h0020;
        launch_a(1'b1, lat);
        chk("toggle_latency", lat, 65);
        chk("toggle_err", int'(err_a), 1);
        chk("toggle_fail_idx", int'(fi_a), 1);

        // start held high: relaunch right after FIN
        corrupt_a = '0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        wait_done_a(1'b0, lat);
        chk("hold_latency1", lat, 65);
        @(posedge clk); #1;
        chk("hold_relaunch_busy", int'(busy_a), 1);
        chk("hold_relaunch_done_clr", int'(done_a), 0);
        chk("hold_relaunch_drive", int'(drv_a()), int'(spec_drive(0)));
        start_a = 1'b0;
        wait_done_a(1'b0, lat);
        chk("hold_latency2", lat, 65);
        chk("hold_pass2", int'(pass_a), 1);

        // reset during mode 1 idx 2 with errors already counted
        corrupt_a = 16'h000f;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 0;
        while (!(ui_a == 2'd1 && {a1_a, a0_a} == 2'd2) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("midrst_reached", int'(lat < 100), 1);
        chk("midrst_err_before", int'(err_a), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_err", int'(err_a), 0);
        chk("midrst_fail_valid", int'(fv_a), 0);
        chk("midrst_fail_mode", int'(fm_a), 0);
        chk("midrst_fail_idx", int'(fi_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_drive", int'(drv_a()), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        corrupt_a = '0;
        launch_a(1'b0, lat);
        chk("postrst_latency", lat, 65);
        chk("postrst_err", int'(err_a), 0);
        chk("postrst_pass", int'(pass_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
